// File: rtl/pid_pkg.sv
// rtl/pid_pkg.sv - shared widths, coefficient layout and FSM encoding for the PID core
package pid_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int NUM_CHN    = 4;
  localparam int CHN_WIDTH  = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1;
  localparam int FRAC_BITS  = 7;
  localparam int ACC_WIDTH  = 2 * DATA_WIDTH + 3;

  // Coefficient word slots, LSB first: min, max, b2, b1, b0, a3, a2, a1
  localparam int NUM_COEF = 8;
  localparam int SLOT_MIN = 0;
  localparam int SLOT_MAX = 1;
  localparam int SLOT_B2  = 2;
  localparam int SLOT_B1  = 3;
  localparam int SLOT_B0  = 4;
  localparam int SLOT_A3  = 5;
  localparam int SLOT_A2  = 6;
  localparam int SLOT_A1  = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_SAT  = 2'd2
  } state_e;

endpackage

// File: rtl/pid_controller_core_if.sv
// rtl/pid_controller_core_if.sv - coefficient, sample and result signals of the PID core
interface pid_controller_core_if #(
  parameter int DATA_WIDTH = pid_pkg::DATA_WIDTH,
  parameter int CHN_WIDTH  = pid_pkg::CHN_WIDTH
);

  logic                         param_valid_i;
  logic [CHN_WIDTH-1:0]         param_chn_i;
  logic signed [DATA_WIDTH-1:0] param_a1_i;
  logic signed [DATA_WIDTH-1:0] param_a2_i;
  logic signed [DATA_WIDTH-1:0] param_a3_i;
  logic signed [DATA_WIDTH-1:0] param_b0_i;
  logic signed [DATA_WIDTH-1:0] param_b1_i;
  logic signed [DATA_WIDTH-1:0] param_b2_i;
  logic signed [DATA_WIDTH-1:0] param_max_i;
  logic signed [DATA_WIDTH-1:0] param_min_i;
  logic                         data_valid_i;
  logic [CHN_WIDTH-1:0]         data_chn_i;
  logic signed [DATA_WIDTH-1:0] data_fdb_i;
  logic signed [DATA_WIDTH-1:0] data_ref_i;
  logic                         tready_o;
  logic                         u_valid_o;
  logic [CHN_WIDTH-1:0]         u_chn_o;
  logic signed [DATA_WIDTH-1:0] u_data_o;

  modport master (
    output param_valid_i, param_chn_i, param_a1_i, param_a2_i, param_a3_i,
           param_b0_i, param_b1_i, param_b2_i, param_max_i, param_min_i,
           data_valid_i, data_chn_i, data_fdb_i, data_ref_i,
    input  tready_o, u_valid_o, u_chn_o, u_data_o
  );

  modport slave (
    input  param_valid_i, param_chn_i, param_a1_i, param_a2_i, param_a3_i,
           param_b0_i, param_b1_i, param_b2_i, param_max_i, param_min_i,
           data_valid_i, data_chn_i, data_fdb_i, data_ref_i,
    output tready_o, u_valid_o, u_chn_o, u_data_o
  );

endinterface

// File: rtl/pid_coef_bank.sv
// rtl/pid_coef_bank.sv - per-channel coefficient/limit register file, one write port, one read port
module pid_coef_bank
  import pid_pkg::*;
#(
  parameter int  DATA_WIDTH = pid_pkg::DATA_WIDTH,
  parameter int  NUM_CHN    = pid_pkg::NUM_CHN,
  localparam int CHN_WIDTH  = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1,
  localparam int WORD_WIDTH = NUM_COEF * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [CHN_WIDTH-1:0]  wr_chn,
  input  logic [WORD_WIDTH-1:0] wr_word,
  input  logic [CHN_WIDTH-1:0]  rd_chn,
  output logic [WORD_WIDTH-1:0] rd_word
);

  logic [WORD_WIDTH-1:0] coef_q [NUM_CHN];
  logic [WORD_WIDTH-1:0] coef_d [NUM_CHN];

  always_comb begin
    coef_d = coef_q;
    if (wr_en && (32'(wr_chn) < NUM_CHN)) begin
      coef_d[wr_chn] = wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHN; i++) begin
        coef_q[i] <= '0;
      end
    end else begin
      coef_q <= coef_d;
    end
  end

  // Reads the registered contents, so a same-edge write is seen only by later reads
  assign rd_word = (32'(rd_chn) < NUM_CHN) ? coef_q[rd_chn] : '0;

endmodule

// File: rtl/pid_controller_core.sv
// rtl/pid_controller_core.sv - multi-channel IIR-form PID: one shared multiplier, 8-cycle sample period
module pid_controller_core
  import pid_pkg::*;
#(
  parameter int  DATA_WIDTH = pid_pkg::DATA_WIDTH,
  parameter int  NUM_CHN    = pid_pkg::NUM_CHN,
  parameter int  FRAC_BITS  = pid_pkg::FRAC_BITS,
  localparam int CHN_WIDTH  = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1,
  localparam int ACC_WIDTH  = 2 * DATA_WIDTH + 3,
  localparam int WORD_WIDTH = NUM_COEF * DATA_WIDTH
) (
  input logic                  clk,
  input logic                  rst,
  pid_controller_core_if.slave bus
);

  localparam int DW = DATA_WIDTH;

  state_e                  state_q, state_d;
  logic [CHN_WIDTH-1:0]    chn_q, chn_d;
  logic signed [DW-1:0]    e0_q, e0_d;
  logic [WORD_WIDTH-1:0]   snap_q, snap_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [2:0]              term_q, term_d;
  logic                    u_valid_q, u_valid_d;
  logic [CHN_WIDTH-1:0]    u_chn_q, u_chn_d;
  logic signed [DW-1:0]    u_data_q, u_data_d;

  logic signed [DW-1:0] e1_q [NUM_CHN];
  logic signed [DW-1:0] e2_q [NUM_CHN];
  logic signed [DW-1:0] u1_q [NUM_CHN];
  logic signed [DW-1:0] u2_q [NUM_CHN];
  logic signed [DW-1:0] u3_q [NUM_CHN];
  logic signed [DW-1:0] e1_d [NUM_CHN];
  logic signed [DW-1:0] e2_d [NUM_CHN];
  logic signed [DW-1:0] u1_d [NUM_CHN];
  logic signed [DW-1:0] u2_d [NUM_CHN];
  logic signed [DW-1:0] u3_d [NUM_CHN];

  logic [WORD_WIDTH-1:0] bank_word;

  pid_coef_bank #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_CHN   (NUM_CHN)
  ) u_coef_bank (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (bus.param_valid_i),
    .wr_chn (bus.param_chn_i),
    .wr_word({bus.param_a1_i, bus.param_a2_i, bus.param_a3_i, bus.param_b0_i,
              bus.param_b1_i, bus.param_b2_i, bus.param_max_i, bus.param_min_i}),
    .rd_chn (bus.data_chn_i),
    .rd_word(bank_word)
  );

  logic signed [DW-1:0] c_a1, c_a2, c_a3, c_b0, c_b1, c_b2, c_max, c_min;
  assign c_a1  = snap_q[SLOT_A1*DW +: DW];
  assign c_a2  = snap_q[SLOT_A2*DW +: DW];
  assign c_a3  = snap_q[SLOT_A3*DW +: DW];
  assign c_b0  = snap_q[SLOT_B0*DW +: DW];
  assign c_b1  = snap_q[SLOT_B1*DW +: DW];
  assign c_b2  = snap_q[SLOT_B2*DW +: DW];
  assign c_max = snap_q[SLOT_MAX*DW +: DW];
  assign c_min = snap_q[SLOT_MIN*DW +: DW];

  // Error is formed one bit wider, then clamped back into DW bits
  logic [DW:0]          diff;
  logic signed [DW-1:0] e0_sat;
  assign diff = {bus.data_ref_i[DW-1], bus.data_ref_i} - {bus.data_fdb_i[DW-1], bus.data_fdb_i};

  always_comb begin
    e0_sat = diff[DW-1:0];
    if (diff[DW] != diff[DW-1]) begin
      e0_sat = diff[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
  end

  // Out-of-range channels see zero history and never write it back
  logic                 chn_ok;
  logic signed [DW-1:0] h_e1, h_e2, h_u1, h_u2, h_u3;
  assign chn_ok = 32'(chn_q) < NUM_CHN;

  always_comb begin
    h_e1 = '0;
    h_e2 = '0;
    h_u1 = '0;
    h_u2 = '0;
    h_u3 = '0;
    if (chn_ok) begin
      h_e1 = e1_q[chn_q];
      h_e2 = e2_q[chn_q];
      h_u1 = u1_q[chn_q];
      h_u2 = u2_q[chn_q];
      h_u3 = u3_q[chn_q];
    end
  end

  logic signed [DW-1:0]        mul_a, mul_b;
  logic signed [2*DW-1:0]      product;
  logic signed [ACC_WIDTH-1:0] product_ext;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (term_q)
      3'd0: begin mul_a = c_b0; mul_b = e0_q; end
      3'd1: begin mul_a = c_b1; mul_b = h_e1; end
      3'd2: begin mul_a = c_b2; mul_b = h_e2; end
      3'd3: begin mul_a = c_a1; mul_b = h_u1; end
      3'd4: begin mul_a = c_a2; mul_b = h_u2; end
      3'd5: begin mul_a = c_a3; mul_b = h_u3; end
      default: ;
    endcase
  end

  assign product     = mul_a * mul_b;
  assign product_ext = $signed({{(ACC_WIDTH-2*DW){product[2*DW-1]}}, product});

  // The max test is evaluated first so an inverted limit pair resolves to max
  logic signed [ACC_WIDTH-1:0] y, max_ext, min_ext;
  logic signed [DW-1:0]        result;
  assign y       = acc_q >>> FRAC_BITS;
  assign max_ext = $signed({{(ACC_WIDTH-DW){c_max[DW-1]}}, c_max});
  assign min_ext = $signed({{(ACC_WIDTH-DW){c_min[DW-1]}}, c_min});

  always_comb begin
    result = y[DW-1:0];
    if (y > max_ext) begin
      result = c_max;
    end else if (y < min_ext) begin
      result = c_min;
    end
  end

  always_comb begin
    state_d   = state_q;
    chn_d     = chn_q;
    e0_d      = e0_q;
    snap_d    = snap_q;
    acc_d     = acc_q;
    term_d    = term_q;
    u_valid_d = 1'b0;
    u_chn_d   = u_chn_q;
    u_data_d  = u_data_q;
    e1_d      = e1_q;
    e2_d      = e2_q;
    u1_d      = u1_q;
    u2_d      = u2_q;
    u3_d      = u3_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.data_valid_i) begin
          state_d = ST_MAC;
          chn_d   = bus.data_chn_i;
          e0_d    = e0_sat;
          snap_d  = bank_word;
          acc_d   = '0;
          term_d  = '0;
        end
      end
      ST_MAC: begin
        acc_d  = acc_q + product_ext;
        term_d = term_q + 3'd1;
        if (term_q == 3'd5) begin
          state_d = ST_SAT;
        end
      end
      ST_SAT: begin
        state_d = ST_IDLE;
        if (chn_ok) begin
          u_valid_d   = 1'b1;
          u_chn_d     = chn_q;
          u_data_d    = result;
          e2_d[chn_q] = h_e1;
          e1_d[chn_q] = e0_q;
          u3_d[chn_q] = h_u2;
          u2_d[chn_q] = h_u1;
          u1_d[chn_q] = result;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      chn_q     <= '0;
      e0_q      <= '0;
      snap_q    <= '0;
      acc_q     <= '0;
      term_q    <= '0;
      u_valid_q <= 1'b0;
      u_chn_q   <= '0;
      u_data_q  <= '0;
      for (int i = 0; i < NUM_CHN; i++) begin
        e1_q[i] <= '0;
        e2_q[i] <= '0;
        u1_q[i] <= '0;
        u2_q[i] <= '0;
        u3_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      chn_q     <= chn_d;
      e0_q      <= e0_d;
      snap_q    <= snap_d;
      acc_q     <= acc_d;
      term_q    <= term_d;
      u_valid_q <= u_valid_d;
      u_chn_q   <= u_chn_d;
      u_data_q  <= u_data_d;
      e1_q      <= e1_d;
      e2_q      <= e2_d;
      u1_q      <= u1_d;
      u2_q      <= u2_d;
      u3_q      <= u3_d;
    end
  end

  assign bus.tready_o  = (state_q == ST_IDLE);
  assign bus.u_valid_o = u_valid_q;
  assign bus.u_chn_o   = u_chn_q;
  assign bus.u_data_o  = u_data_q;

endmodule

// File: tb/tb_pid_controller_core.sv
// tb/tb_pid_controller_core.sv - directed vectors with a queue scoreboard for pid_controller_core
module tb_pid_controller_core;
  import pid_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;

  typedef struct {
    int chn;
    int data;
    int cyc;
  } exp_t;

  exp_t sb[$];

  pid_controller_core_if #(.DATA_WIDTH(DATA_WIDTH), .CHN_WIDTH(CHN_WIDTH)) bus ();

  pid_controller_core dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.u_valid_o) begin
      if (sb.size() == 0) begin
        check("unexpected_u_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("u_data", int'(bus.u_data_o), e.data);
        check("u_chn", int'(bus.u_chn_o), e.chn);
        check("u_latency", cyc - e.cyc, 8);
      end
    end
  end

  task automatic set_params(input int ch, input int a1, input int a2, input int a3,
                            input int b0, input int b1, input int b2,
                            input int mx, input int mn);
    bus.param_chn_i = CHN_WIDTH'(ch);
    bus.param_a1_i  = DATA_WIDTH'(a1);
    bus.param_a2_i  = DATA_WIDTH'(a2);
    bus.param_a3_i  = DATA_WIDTH'(a3);
    bus.param_b0_i  = DATA_WIDTH'(b0);
    bus.param_b1_i  = DATA_WIDTH'(b1);
    bus.param_b2_i  = DATA_WIDTH'(b2);
    bus.param_max_i = DATA_WIDTH'(mx);
    bus.param_min_i = DATA_WIDTH'(mn);
  endtask

  task automatic program_ch(input int ch, input int a1, input int a2, input int a3,
                            input int b0, input int b1, input int b2,
                            input int mx, input int mn);
    set_params(ch, a1, a2, a3, b0, b1, b2, mx, mn);
    bus.param_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.param_valid_i = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.tready_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) check("tready_timeout", 0, 1);
  endtask

  task automatic send(input int ch, input int r, input int f, input int exp_v);
    bus.data_chn_i   = CHN_WIDTH'(ch);
    bus.data_ref_i   = DATA_WIDTH'(r);
    bus.data_fdb_i   = DATA_WIDTH'(f);
    bus.data_valid_i = 1'b1;
    wait_ready();
    sb.push_back('{ch, exp_v, cyc});
    @(posedge clk); #1;
    bus.data_valid_i = 1'b0;
  endtask

  task automatic drain();
    repeat (12) @(posedge clk);
    #1;
  endtask

  initial begin
    int n_acc;
    int last_k;

    bus.param_valid_i = 1'b0;
    bus.data_valid_i  = 1'b0;
    bus.data_chn_i    = '0;
    bus.data_ref_i    = '0;
    bus.data_fdb_i    = '0;
    set_params(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_tready", int'(bus.tready_o), 1);
    check("rst_u_valid", int'(bus.u_valid_o), 0);
    check("rst_u_chn", int'(bus.u_chn_o), 0);
    check("rst_u_data", int'(bus.u_data_o), 0);

    // Saturation and latency on channel 0
    program_ch(0, 0, 0, 0, 128, 0, 0, 1500, -200);
    send(0, 100, 0, 100);
    send(0, 2000, 0, 1500);
    send(0, 0, 500, -200);
    drain();

    // Output history on channel 1
    program_ch(1, 128, 0, 0, 128, 0, 0, 1500, -200);
    send(1, 10, 0, 10);
    send(1, 10, 0, 20);
    drain();

    // Back-to-back channels, then probe each channel's stored history
    for (int c = 0; c < NUM_CHN; c++) program_ch(c, 0, 0, 0, 128, 0, 0, 1500, -200);
    for (int c = 0; c < NUM_CHN; c++) send(c, 10 * (c + 1), 0, 10 * (c + 1));
    drain();
    program_ch(2, 128, 0, 0, 0, 0, 0, 1500, -200);
    send(2, 0, 0, 30);
    program_ch(3, 0, 0, 0, 0, 128, 0, 1500, -200);
    send(3, 0, 0, 40);
    drain();

    // Inverted limits resolve to max; error saturation at both rails
    program_ch(2, 0, 0, 0, 128, 0, 0, -50, 50);
    send(2, 0, 0, -50);
    program_ch(3, 0, 0, 0, 1, 0, 0, 32767, -32768);
    send(3, 32767, -32768, 255);
    send(3, -32768, 32767, -256);
    drain();

    // data_valid held high: one acceptance every 8 cycles
    n_acc  = 0;
    last_k = -1;
    bus.data_chn_i   = '0;
    bus.data_fdb_i   = '0;
    bus.data_ref_i   = DATA_WIDTH'(5);
    bus.data_valid_i = 1'b1;
    for (int k = 0; k < 24; k++) begin
      if (bus.tready_o) begin
        n_acc++;
        sb.push_back('{0, 5 * n_acc, cyc});
        if (last_k >= 0) check("hs_gap", k - last_k, 8);
        last_k = k;
      end
      @(posedge clk); #1;
      bus.data_ref_i = DATA_WIDTH'(5 * (n_acc + 1));
    end
    bus.data_valid_i = 1'b0;
    check("hs_accepts", n_acc, 3);
    drain();

    // Coefficient write on the acceptance edge of the same channel
    wait_ready();
    set_params(0, 0, 0, 0, 256, 0, 0, 1500, -200);
    bus.param_valid_i = 1'b1;
    bus.data_chn_i    = '0;
    bus.data_ref_i    = DATA_WIDTH'(100);
    bus.data_fdb_i    = '0;
    bus.data_valid_i  = 1'b1;
    sb.push_back('{0, 100, cyc});
    @(posedge clk); #1;
    bus.param_valid_i = 1'b0;
    bus.data_valid_i  = 1'b0;
    send(0, 100, 0, 200);
    drain();

    // Reset during MAC aborts the sample and clears state
    bus.data_chn_i   = '0;
    bus.data_ref_i   = DATA_WIDTH'(100);
    bus.data_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.data_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_tready", int'(bus.tready_o), 1);
    check("abort_u_valid", int'(bus.u_valid_o), 0);
    check("abort_u_chn", int'(bus.u_chn_o), 0);
    check("abort_u_data", int'(bus.u_data_o), 0);
    drain();

    // History cleared by reset: u1 starts from zero again
    program_ch(0, 128, 0, 0, 128, 0, 0, 1500, -200);
    send(0, 10, 0, 10);
    send(0, 10, 0, 20);
    drain();

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pid_controller_core.md
PID_CONTROLLER_CORE -- requirements
Module: pid_controller_core

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 16, signed width of coefficients, samples, limits and output.
REQ-002 SHALL have parameter NUM_CHN, 4, number of independent PID channels.
REQ-003 SHALL have parameter FRAC_BITS, 7, arithmetic right shift applied to the accumulator.
REQ-004 SHALL have ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- param_valid_i  in  1  coefficient write strobe.
- param_chn_i  in  CHN_WIDTH  target channel of the write.
- param_a1_i, param_a2_i, param_a3_i  in  DATA_WIDTH  output-history coefficients (signed).
- param_b0_i, param_b1_i, param_b2_i  in  DATA_WIDTH  error-history coefficients (signed).
- param_max_i, param_min_i  in  DATA_WIDTH  signed output clamp limits.
- data_valid_i  in  1  sample valid.
- data_chn_i  in  CHN_WIDTH  sample channel.
- data_fdb_i, data_ref_i  in  DATA_WIDTH  signed feedback and reference.
- tready_o  out  1  core can accept a sample.
- u_valid_o  out  1  one-cycle result strobe.
- u_chn_o  out  CHN_WIDTH  result channel.
- u_data_o  out  DATA_WIDTH  signed control output.
REQ-005 CHN_WIDTH SHALL be clog2(NUM_CHN), minimum 1.

Function
REQ-006 A sample SHALL transfer on a clock edge where data_valid_i && tready_o; tready_o SHALL be high only in IDLE.
REQ-007 The FSM SHALL use the states IDLE -> MAC (6 cycles) -> SAT -> IDLE; acceptance moves IDLE to MAC, and MAC exits after its 6th term.
REQ-008 At acceptance the core SHALL register the channel, e0 = sat16(ref - fdb) computed at 17 bits, and a snapshot of that channel's 8 coefficients.
REQ-009 MAC SHALL use one signed DATA_WIDTH x DATA_WIDTH multiplier, one term per cycle, into a signed accumulator of 2*DATA_WIDTH+3 bits.
REQ-010 The accumulated sum SHALL be: acc = b0*e0 + b1*e1 + b2*e2 + a1*u1 + a2*u2 + a3*u3, where e1/e2 are the channel's previous errors and u1/u2/u3 its previous outputs.
REQ-011 SAT SHALL compute y = acc >>> FRAC_BITS; if y > max then max, else if y < min then min, else y truncated to DATA_WIDTH.
REQ-012 The max comparison SHALL take priority, so that min > max yields max.
REQ-013 In SAT the core SHALL register u_data_o and u_chn_o and shift history: e2<=e1, e1<=e0, u3<=u2, u2<=u1, u1<=result.
REQ-014 u_valid_o SHALL be high for exactly the one cycle after the SAT edge; that cycle is 8 edges after acceptance.
REQ-015 tready_o SHALL be high again in the same cycle as u_valid_o, giving a maximum throughput of 1 sample per 8 cycles.
REQ-016 u_data_o and u_chn_o SHALL hold their last values while u_valid_o is low.
REQ-017 param_valid_i SHALL write all 8 coefficients of param_chn_i in any FSM state.
REQ-018 A coefficient write to the channel in computation SHALL affect only later samples.
REQ-019 When a write and an acceptance for the same channel fall on the same edge, the snapshot SHALL take the old values.
REQ-020 A sample with data_chn_i >= NUM_CHN SHALL be accepted and run through the FSM, with no u_valid_o and no history update.
REQ-021 data_valid_i asserted while tready_o is low SHALL be ignored, not queued.

Reset
REQ-022 On rst the FSM SHALL enter IDLE and tready_o SHALL be 1; u_valid_o, u_chn_o, u_data_o and the accumulator SHALL be 0.
REQ-023 On rst all coefficients, limits and per-channel history SHALL be 0.
REQ-024 rst asserted mid-MAC or in SAT SHALL abort the sample with no u_valid_o and no history update.

Structure
REQ-025 Package pid_pkg SHALL hold DATA_WIDTH, NUM_CHN, CHN_WIDTH, FRAC_BITS, ACC_WIDTH and the FSM state encoding.
REQ-026 Sub-module pid_coef_bank SHALL contain the per-channel coefficient and limit register file with its write port and a read-by-channel port.
REQ-027 The history registers and the MAC/FSM SHALL stay in pid_controller_core.

Verification
REQ-028 Saturation and latency: ch0 b0=128, others 0, max=1500, min=-200; send ref=100, fdb=0 -> u_valid_o 8 cycles later, u_chn_o=0, u_data_o=100; send ref=2000 -> 1500; send ref=0, fdb=500 -> -200.
REQ-029 History: ch1 a1=128, b0=128, max=1500, min=-200; send ref=10, fdb=0 twice -> outputs 10 then 20.
REQ-030 Isolation and order: program all channels as REQ-028 and send channels 0..3 back-to-back with ref=10,20,30,40 -> outputs in order 10,20,30,40, and per-channel history unaffected by other channels.
REQ-031 Handshake: hold data_valid_i high continuously -> tready_o low for 7 cycles after each acceptance, exactly one acceptance per 8 cycles, no sample duplicated or lost.
REQ-032 Write collision: write ch0 b0=256 on the acceptance edge of a ch0 sample with ref=100 -> output 100; the next sample gives 200.
REQ-033 Abort: assert rst during MAC -> no u_valid_o, tready_o=1 on the next cycle, all outputs 0.
